// File: rtl/bcd_serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bundle for the serial BCD adder.
// The master requests an operation; the slave returns the result.
interface bcd_serial_adder_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                  start;
    logic [4*N_DIGITS-1:0] x;
    logic [4*N_DIGITS-1:0] y;
    logic                  op;
    logic                  busy;
    logic                  done;
    logic [4*N_DIGITS-1:0] z;
    logic                  c_out;
    logic                  err;

    modport master (
        output start, x, y, op,
        input  busy, done, z, c_out, err
    );

    modport slave (
        input  start, x, y, op,
        output busy, done, z, c_out, err
    );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder: one shared digit stage, LSD first, registered carry.
// Define BCD_SUB_EN to add nines'-complement subtraction selected by op.
module bcd_serial_adder_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int CNT_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst_b,
    bcd_serial_adder_ctrl_if.slave  io
);
    localparam int W = 4 * N_DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     x_q, y_q, z_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cy_q;
    logic             c_out_q;
    logic             err_q;
    logic             busy, done;

    logic             start_acc;
    logic             last;
    logic [3:0]       xd, yd, yd_eff, dig;
    logic [4:0]       s;
    logic             cy_nxt;
    logic             c_fin;

`ifdef BCD_SUB_EN
    logic             op_q;
`else
    logic             unused_op;
    assign unused_op = io.op;
`endif

    assign start_acc = (state_q == IDLE) && io.start;
    assign last      = (cnt_q == CNT_W'(N_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io.start) state_d = ADD;
            ADD:     if (last)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ADD:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Single-digit stage; invalid digits still get the +6 correction
    always_comb begin
        xd = x_q[3:0];
        yd = y_q[3:0];
`ifdef BCD_SUB_EN
        yd_eff = op_q ? (4'd9 - yd) : yd;
`else
        yd_eff = yd;
`endif
        s = {1'b0, xd} + {1'b0, yd_eff} + {4'b0, cy_q};
        if (s > 5'd9) begin
            dig    = s[3:0] + 4'd6;
            cy_nxt = 1'b1;
        end else begin
            dig    = s[3:0];
            cy_nxt = 1'b0;
        end
`ifdef BCD_SUB_EN
        c_fin = op_q ? ~cy_nxt : cy_nxt;
`else
        c_fin = cy_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (start_acc) begin
            x_q   <= io.x;
            y_q   <= io.y;
            z_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
`ifdef BCD_SUB_EN
            cy_q  <= io.op;
`else
            cy_q  <= 1'b0;
`endif
        end else if (state_q == ADD) begin
            x_q   <= {4'b0, x_q[W-1:4]};
            y_q   <= {4'b0, y_q[W-1:4]};
            z_q   <= {dig, z_q[W-1:4]};
            cy_q  <= cy_nxt;
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (xd > 4'd9 || yd > 4'd9) err_q <= 1'b1;
            if (last) c_out_q <= c_fin;
        end
    end

`ifdef BCD_SUB_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)         op_q <= 1'b0;
        else if (start_acc) op_q <= io.op;
    end
`endif

    assign io.busy  = busy;
    assign io.done  = done;
    assign io.z     = z_q;
    assign io.c_out = c_out_q;
    assign io.err   = err_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Bench for bcd_serial_adder_ctrl: directed and random operations with a
// decimal-arithmetic reference model and a done-driven scoreboard.
module tb_bcd_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] z;
        logic         c;
        logic         e;
        bit           chk_z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b;
    int   total = 0;
    int   bad = 0;
    int   n_exp = 0;
    int   n_done = 0;
    exp_t sb[$];
    exp_t last_e;

    bcd_serial_adder_ctrl_if #(.N_DIGITS(N)) bus ();

    bcd_serial_adder_ctrl #(.N_DIGITS(N), .CNT_W(3)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .io   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic int dec(input logic [W-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] xv, yv, input bit opv);
        exp_t e;
        int   lim = 1;
        int   r;
        bit   sub = 1'b0;
        for (int i = 0; i < N; i++) lim = lim * 10;
        e.e = 1'b0;
        for (int i = 0; i < N; i++)
            if (xv[4*i +: 4] > 4'd9 || yv[4*i +: 4] > 4'd9) e.e = 1'b1;
`ifdef BCD_SUB_EN
        sub = opv;
`endif
        if (sub) begin
            r   = dec(xv) - dec(yv);
            e.c = (r < 0);
            if (r < 0) r = r + lim;
        end else begin
            r   = dec(xv) + dec(yv) + (opv & 1'b0);
            e.c = (r >= lim);
            r   = r % lim;
        end
        e.z     = to_bcd(r);
        e.chk_z = !e.e;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_b === 1'b1 && bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb: done pulse with no expected result");
            end else begin
                e = sb.pop_front();
                if (e.chk_z) begin
                    chk("z", 32'(bus.z), 32'(e.z));
                    chk("c_out", 32'(bus.c_out), 32'(e.c));
                end
                chk("err", 32'(bus.err), 32'(e.e));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] xv, yv, input bit opv,
                          input bit poke);
        last_e = model(xv, yv, opv);
        sb.push_back(last_e);
        n_exp++;
        @(negedge clk);
        bus.start = 1'b1;
        bus.x = xv;
        bus.y = yv;
        bus.op = opv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.x = W'($urandom);
        bus.y = W'($urandom);
        for (int i = 0; i < N; i++) begin
            chk("busy", 32'(bus.busy), 32'd1);
            chk("done_early", 32'(bus.done), 32'd0);
            if (poke && i == 1) begin
                bus.start = 1'b1;
                bus.x = to_bcd(4321);
                bus.y = to_bcd(1111);
            end
            @(negedge clk);
            if (poke && i == 1) bus.start = 1'b0;
        end
        chk("done_lat", 32'(bus.done), 32'd1);
        chk("busy_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        if (last_e.chk_z) chk("z_hold", 32'(bus.z), 32'(last_e.z));
        chk("err_hold", 32'(bus.err), 32'(last_e.e));
    endtask

    task automatic abort_op();
        @(negedge clk);
        bus.start = 1'b1;
        bus.x = to_bcd(1234);
        bus.y = to_bcd(5678);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_c_out", 32'(bus.c_out), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (N + 2) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] xv, yv;
        rst_b = 1'b0;
        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.op = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_busy", 32'(bus.busy), 32'd0);
        chk("init_done", 32'(bus.done), 32'd0);
        chk("init_z", 32'(bus.z), 32'd0);
        chk("init_c_out", 32'(bus.c_out), 32'd0);
        chk("init_err", 32'(bus.err), 32'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        run_op(to_bcd(1234), to_bcd(5678), 1'b0, 1'b0);
        run_op(to_bcd(9999), to_bcd(1), 1'b0, 1'b0);
        run_op(to_bcd(999), to_bcd(1), 1'b0, 1'b0);
        run_op(to_bcd(2468), to_bcd(1357), 1'b0, 1'b1);
        abort_op();
        run_op(to_bcd(5), to_bcd(5), 1'b0, 1'b0);
        xv = 16'h12A4;
        run_op(xv, to_bcd(1), 1'b0, 1'b0);
        run_op(to_bcd(4000), to_bcd(6000), 1'b0, 1'b0);
`ifdef BCD_SUB_EN
        run_op(to_bcd(100), to_bcd(1), 1'b1, 1'b0);
        run_op(to_bcd(1), to_bcd(2), 1'b1, 1'b0);
        run_op(to_bcd(5000), to_bcd(5000), 1'b1, 1'b0);
`endif

        for (int k = 0; k < 40; k++) begin
            xv = to_bcd(int'($urandom_range(0, 9999)));
            yv = to_bcd(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 4) == 0) begin
                int p = int'($urandom_range(0, N - 1));
                if ($urandom_range(0, 1) == 0)
                    xv[4*p +: 4] = 4'($urandom_range(10, 15));
                else
                    yv[4*p +: 4] = 4'($urandom_range(10, 15));
            end
            run_op(xv, yv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("done_count", 32'(n_done), 32'(n_exp));
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
